// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter: shares one line-wide memory port between the I-refill port and
// the D-cache port. One transaction in flight; round-robin on ties; registered
// memory-side outputs; sticky watchdog error when the memory never acks.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   i_req_i/i_write_i/i_addr_i/i_data_i   port I request, held until i_ack_o
//   i_data_o, i_ack_o            port I response line and completion pulse
//   d_* (same set)               port D
//   mem_enable_o/mem_write_o/mem_addr_o/mem_data_o   memory request
//   mem_data_i, mem_ack_i        memory read line and completion pulse
//   busy_o                       transaction in GRANT or RESP
//   err_o                        sticky watchdog error
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic              i_write_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  input  logic [DATA_W-1:0] i_data_i,
  output logic [DATA_W-1:0] i_data_o,
  output logic              i_ack_o,
  input  logic              d_req_i,
  input  logic              d_write_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_data_i,
  output logic [DATA_W-1:0] d_data_o,
  output logic              d_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic              busy_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic             PORT_I      = 1'b0;
  localparam logic             PORT_D      = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic             WDOG_ON     = (TIMEOUT != 0);

  state_t            state_q;
  logic              owner_q;
  logic              last_grant_q;
  logic [CNT_W-1:0]  wdog_q;
  logic [DATA_W-1:0] rsp_q;

  logic              grant_d_c;
  logic [CNT_W-1:0]  wdog_inc_c;

  // D wins when alone, or on a tie when I was granted last.
  assign grant_d_c  = d_req_i & (~i_req_i | (last_grant_q == PORT_I));

  // Saturating watchdog increment so a very long stall cannot wrap.
  assign wdog_inc_c = (wdog_q == CNT_MAX) ? wdog_q : wdog_q + CNT_W'(1);

  // Both ports see the same response register.
  assign i_data_o = rsp_q;
  assign d_data_o = rsp_q;

  // Arbiter FSM with registered outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      owner_q      <= PORT_I;
      last_grant_q <= PORT_I;
      wdog_q       <= '0;
      rsp_q        <= '0;
      i_ack_o      <= 1'b0;
      d_ack_o      <= 1'b0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      busy_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      i_ack_o <= 1'b0;
      d_ack_o <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_req_i || d_req_i) begin
            owner_q      <= grant_d_c;
            last_grant_q <= grant_d_c;
            mem_write_o  <= grant_d_c ? d_write_i : i_write_i;
            mem_addr_o   <= grant_d_c ? d_addr_i  : i_addr_i;
            mem_data_o   <= grant_d_c ? d_data_i  : i_data_i;
            mem_enable_o <= 1'b1;
            busy_o       <= 1'b1;
            wdog_q       <= '0;
            state_q      <= GRANT;
          end
        end
        GRANT: begin
          if (mem_ack_i) begin
            rsp_q        <= mem_data_i;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            wdog_q       <= '0;
            // Ack is raised here so it is visible during the RESP cycle.
            i_ack_o      <= (owner_q == PORT_I);
            d_ack_o      <= (owner_q == PORT_D);
            state_q      <= RESP;
          end else begin
            wdog_q <= wdog_inc_c;
            // Fires once TIMEOUT busy cycles have elapsed; transfer keeps going.
            if (WDOG_ON && (wdog_inc_c == CNT_TIMEOUT)) begin
              err_o <= 1'b1;
            end
          end
        end
        RESP: begin
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          mem_enable_o <= 1'b0;
          mem_write_o  <= 1'b0;
          busy_o       <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

endmodule
